hpdl_write_scheduler: RTL and testbench
=======================================

# hpdl_write_scheduler

Single-clock controller that owns the 16-character HPDL-1414 text buffer and sequences all writes to the four displays. Accepts characters from a host requester (UART receive path) over a valid/ready handshake, handles cursor control codes, and schedules display writes from a per-position dirty map with explicit setup, strobe and hold phases. Replaces derived-clock write strobing with fully synchronous WR pulse generation.

## Interface
- SETUP_CYC, 4: cycles address/data are stable before WR falls (1..255)
- PULSE_CYC, 8: cycles WR is held low (1..255)
- HOLD_CYC, 4: cycles address/data are held after WR rises (1..255)
- BLINK_W, 23: width of the free-running caret blink counter; phase = MSB
- CLK  in  1: system clock (12 MHz); one clock, all logic on posedge
- RST_N  in  1: reset, asynchronous and active-low
- i_char_valid  in  1: host character valid
- i_char_data  in  8: host character code
- o_char_ready  out  1: character accepted when valid & ready on a posedge
- o_cursor  out  4: current cursor position, 0 = leftmost
- o_busy  out  1: display write in progress or any dirty bit set
- HPDL_D  out  7: display data bus
- HPDL_A  out  2: digit address within one display
- HPDL_WR_N  out  4: per-display write strobes, active-low

## Operation
- Storage: 16 x 7-bit buffer, 16-bit dirty map, 4-bit cursor.
- Position p maps to display p[3:2] (HPDL_WR_N[p[3:2]]) and HPDL_A = ~p[1:0], so p = 0 is leftmost.
- Host codes (on accept):
  - 0x20..0x5F: store at cursor, dirty[cursor]=1, cursor += 1 saturating at 15 (further chars overwrite position 15).
  - 0x61..0x7A: folded to uppercase (minus 0x20), then as above.
  - 0x08 BKSP: if cursor > 0, cursor -= 1, store 0x20 there, mark dirty; at 0 no effect.
  - 0x0D CR: cursor = 0, buffer unchanged.
  - 0x0C FF: enter CLEAR; buffer[i]=0x20 and dirty[i]=1 for i = 0..15, one entry per cycle; cursor = 0 at end.
  - All other codes: accepted and discarded.
- o_char_ready = 0 in CLEAR and during reset, else 1.
- Write FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: if any dirty bit set, select first dirty position at or after scan pointer (round-robin, wraps 15 -> 0); latch index and glyph onto HPDL_A/HPDL_D; clear that dirty bit; scan pointer = index + 1; -> SETUP.
  - SETUP: SETUP_CYC cycles -> STROBE. STROBE: selected WR_N low for PULSE_CYC cycles -> HOLD. HOLD: HOLD_CYC cycles, bus unchanged -> IDLE.
- Simultaneous host write and FSM clear of the same dirty bit: set wins, so the newer char is rewritten.
- Host writes during SETUP/STROBE/HOLD do not disturb the latched bus.
- Reset: buffer all 0x20, dirty all 1 (display blanked after reset), cursor 0, scan pointer 0, FSM IDLE.

## Timing
- Reset values: HPDL_WR_N = 4'b1111 (asynchronous on RST_N fall, including mid-strobe), HPDL_D = 0x20, HPDL_A = 2'b11, o_cursor = 0, o_char_ready = 0 while RST_N low then 1, o_busy = 1.
- Accept -> buffer/dirty updated at the same edge; FSM may select it the next cycle.
- One display write = 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC cycles (17 at defaults, ~1.4 us).
- Idle display, single char: WR_N falls 1 + SETUP_CYC cycles after the accept edge.
- FF: o_char_ready low for exactly 16 cycles following the accept edge.
- Only one WR_N low at any time; never low outside STROBE.

## Configuration
- HPDL_CARET_EN defined: blink counter runs; when phase = 1 the glyph latched for position == cursor is 0x5F '_' instead of buffer content. Each phase toggle and each cursor move marks dirty the old and new cursor positions.
- Undefined: no blink counter, glyph always buffer content, cursor moves mark nothing extra.

## Test plan
- Release reset -> exactly 16 writes of 0x20, positions 0..15 in order, WR_N[0] for 0..3 with HPDL_A 3,2,1,0; o_busy falls afterwards.
- Send 'a' (0x61) then 'B' -> D = 0x41 at p0, 0x42 at p1; o_cursor = 2; WR_N low width 8 cycles, setup 4, hold 4.
- Send 17 printable chars 'A'..'Q' -> p15 holds 'Q', cursor stays 15; BKSP at cursor 0 -> no write, cursor 0.
- Send 0x0C with i_char_valid held high -> o_char_ready low 16 cycles, all positions rewritten 0x20, cursor 0.
- Assert RST_N low during STROBE -> all WR_N high immediately (asynchronous), no partial write continues after release.
- With HPDL_CARET_EN, BLINK_W = 4 -> position at cursor alternates 0x5F / buffer glyph every 8 cycles; without it, no writes occur when idle.

Source files
------------

// File: rtl/hpdl_write_scheduler_if.sv
// Host character handshake plus HPDL-1414 display bus of hpdl_write_scheduler.
// The master side is the host/board; the slave side is the scheduler.
interface hpdl_write_scheduler_if;
    logic       i_char_valid;
    logic [7:0] i_char_data;
    logic       o_char_ready;
    logic [3:0] o_cursor;
    logic       o_busy;
    logic [6:0] HPDL_D;
    logic [1:0] HPDL_A;
    logic [3:0] HPDL_WR_N;

    modport master (
        output i_char_valid, i_char_data,
        input  o_char_ready, o_cursor, o_busy, HPDL_D, HPDL_A, HPDL_WR_N
    );

    modport slave (
        input  i_char_valid, i_char_data,
        output o_char_ready, o_cursor, o_busy, HPDL_D, HPDL_A, HPDL_WR_N
    );
endinterface

// File: rtl/hpdl_write_scheduler.sv
// Owns the 16-character HPDL-1414 text buffer and schedules synchronous display writes
// from a dirty map. Optional blinking caret: define HPDL_CARET_EN.
module hpdl_write_scheduler #(
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned PULSE_CYC = 8,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned BLINK_W   = 23
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    hpdl_write_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } wr_state_t;

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

    logic [6:0]  buffer_q [16];
    logic [15:0] dirty_q;
    logic [3:0]  cursor_q;
    logic [3:0]  scan_q;
    logic [3:0]  clear_idx_q;
    logic        clearing_q;
    logic        ready_q;
    wr_state_t   state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  disp_q;
    logic [3:0]  wr_n_q;
    logic [6:0]  d_q;
    logic [1:0]  a_q;

    logic [7:0]  code;
    logic        accept;
    logic        printable;
    logic        buf_we;
    logic [3:0]  buf_idx;
    logic [6:0]  buf_val;
    logic [3:0]  cursor_nxt;
    logic        start_clear;
    logic [15:0] set_mask;
    logic [15:0] clr_mask;
    logic        found;
    logic [3:0]  sel_idx;
    logic [3:0]  cand;
    logic [6:0]  glyph;
    logic        caret_phase;
    logic        blink_wrap;

`ifdef HPDL_CARET_EN
    localparam bit CARET_EN = 1'b1;
    logic [BLINK_W-1:0] blink_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + BLINK_W'(1);
        end
    end

    assign caret_phase = blink_q[BLINK_W-1];
    assign blink_wrap  = &blink_q[BLINK_W-2:0];
`else
    localparam bit CARET_EN = 1'b0;
    assign caret_phase = 1'b0;
    assign blink_wrap  = 1'b0;
`endif

    assign code      = bus.i_char_data;
    assign accept    = bus.i_char_valid & ready_q;
    assign printable = ((code >= 8'h20) && (code <= 8'h5F)) ||
                       ((code >= 8'h61) && (code <= 8'h7A));

    // Single buffer write port shared by the CLEAR sweep and host characters.
    always_comb begin
        buf_we      = 1'b0;
        buf_idx     = cursor_q;
        buf_val     = 7'h20;
        cursor_nxt  = cursor_q;
        start_clear = 1'b0;
        if (clearing_q) begin
            buf_we  = 1'b1;
            buf_idx = clear_idx_q;
            if (clear_idx_q == 4'd15) begin
                cursor_nxt = 4'd0;
            end
        end else if (accept) begin
            if (printable) begin
                buf_we     = 1'b1;
                buf_val    = (code >= 8'h61) ? (code[6:0] - 7'h20) : code[6:0];
                cursor_nxt = (cursor_q == 4'd15) ? 4'd15 : cursor_q + 4'd1;
            end else if (code == 8'h08) begin
                if (cursor_q != 4'd0) begin
                    buf_we     = 1'b1;
                    buf_idx    = cursor_q - 4'd1;
                    cursor_nxt = cursor_q - 4'd1;
                end
            end else if (code == 8'h0D) begin
                cursor_nxt = 4'd0;
            end else if (code == 8'h0C) begin
                start_clear = 1'b1;
            end
        end

        set_mask = buf_we ? (16'h0001 << buf_idx) : 16'h0000;
        if (CARET_EN && (cursor_nxt != cursor_q)) begin
            set_mask = set_mask | (16'h0001 << cursor_q) | (16'h0001 << cursor_nxt);
        end
        if (blink_wrap) begin
            set_mask = set_mask | (16'h0001 << cursor_nxt);
        end
    end

    // Round-robin pick of the first dirty position at or after the scan pointer.
    always_comb begin
        found   = 1'b0;
        sel_idx = scan_q;
        cand    = scan_q;
        for (int k = 0; k < 16; k++) begin
            cand = scan_q + 4'(k);
            if (!found && dirty_q[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
        glyph    = (caret_phase && (sel_idx == cursor_q)) ? 7'h5F : buffer_q[sel_idx];
        clr_mask = ((state_q == ST_IDLE) && found) ? (16'h0001 << sel_idx) : 16'h0000;
    end

    // Set is applied after clear so a host write racing the FSM pick is rewritten.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 16; i++) begin
                buffer_q[i] <= 7'h20;
            end
            dirty_q     <= 16'hFFFF;
            cursor_q    <= 4'd0;
            clear_idx_q <= 4'd0;
            clearing_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            if (buf_we) begin
                buffer_q[buf_idx] <= buf_val;
            end
            dirty_q  <= (dirty_q & ~clr_mask) | set_mask;
            cursor_q <= cursor_nxt;
            ready_q  <= ~(start_clear | (clearing_q & (clear_idx_q != 4'd15)));
            if (start_clear) begin
                clearing_q  <= 1'b1;
                clear_idx_q <= 4'd0;
            end else if (clearing_q) begin
                clear_idx_q <= clear_idx_q + 4'd1;
                if (clear_idx_q == 4'd15) begin
                    clearing_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            scan_q  <= 4'd0;
            cnt_q   <= 8'd0;
            disp_q  <= 2'd0;
            wr_n_q  <= 4'b1111;
            d_q     <= 7'h20;
            a_q     <= 2'b11;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        d_q     <= glyph;
                        a_q     <= ~sel_idx[1:0];
                        disp_q  <= sel_idx[3:2];
                        scan_q  <= sel_idx + 4'd1;
                        cnt_q   <= SETUP_LD;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == 8'd0) begin
                        wr_n_q  <= ~(4'b0001 << disp_q);
                        cnt_q   <= PULSE_LD;
                        state_q <= ST_STROBE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == 8'd0) begin
                        wr_n_q  <= 4'b1111;
                        cnt_q   <= HOLD_LD;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    wr_n_q  <= 4'b1111;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_char_ready = ready_q;
    assign bus.o_cursor     = cursor_q;
    assign bus.o_busy       = (state_q != ST_IDLE) | (|dirty_q);
    assign bus.HPDL_D       = d_q;
    assign bus.HPDL_A       = a_q;
    assign bus.HPDL_WR_N    = wr_n_q;

endmodule

// File: tb/tb_hpdl_write_scheduler.sv
// Self-checking bench for hpdl_write_scheduler: reset blanking, table vectors,
// multi-cycle corner sequences and random host traffic against a display model.
module tb_hpdl_write_scheduler;

    localparam int SETUP_CYC = 4;
    localparam int PULSE_CYC = 8;
    localparam int HOLD_CYC  = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    hpdl_write_scheduler_if bus_if ();

    hpdl_write_scheduler #(
        .SETUP_CYC(SETUP_CYC),
        .PULSE_CYC(PULSE_CYC),
        .HOLD_CYC (HOLD_CYC),
        .BLINK_W  (23)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus_if)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] pos;
        logic [6:0] data;
    } wr_rec_t;

    typedef struct {
        logic [7:0] code;
        int         exp_cursor;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned fall_cyc = 0;
    int unsigned acc_cyc = 0;
    logic [6:0]  mbuf [16];
    logic [6:0]  mdisp [16];
    int          mcur = 0;
    wr_rec_t     wlog [$];
    int          gaps [$];
    int          in_low = 0;
    int          low_cnt = 0;
    int          high_cnt = 0;
    int          have_rise = 0;
    int          bus_stable = 0;
    logic [8:0]  prev_bus = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int dispOf(input logic [3:0] wr_n);
        for (int i = 0; i < 4; i++) begin
            if (!wr_n[i]) return i;
        end
        return 0;
    endfunction

    // Watches the display bus: records every write into the display model and
    // checks strobe exclusivity, setup, pulse width and hold.
    always @(negedge CLK) begin
        logic [8:0] bus_now;
        wr_rec_t    rec;
        bus_now = {bus_if.HPDL_D, bus_if.HPDL_A};
        if (!RST_N) begin
            in_low     = 0;
            have_rise  = 0;
            low_cnt    = 0;
            high_cnt   = 0;
            bus_stable = 0;
        end else begin
            if (bus_now != prev_bus) bus_stable = 0;
            else bus_stable++;
            if (bus_if.HPDL_WR_N != 4'hF) begin
                checkOutput("single_strobe", $countones(~bus_if.HPDL_WR_N), 1);
                if (in_low == 0) begin
                    checkOutput("setup_cycles", (bus_stable < SETUP_CYC) ? bus_stable : SETUP_CYC, SETUP_CYC);
                    if (have_rise != 0) gaps.push_back(high_cnt);
                    rec.pos  = {2'(dispOf(bus_if.HPDL_WR_N)), ~bus_if.HPDL_A};
                    rec.data = bus_if.HPDL_D;
                    wlog.push_back(rec);
                    mdisp[rec.pos] = rec.data;
                    fall_cyc = cyc;
                    in_low   = 1;
                    low_cnt  = 0;
                end else if (bus_now != prev_bus) begin
                    checkOutput("bus_stable_in_strobe", int'(bus_now), int'(prev_bus));
                end
                low_cnt++;
            end else begin
                if (in_low != 0) begin
                    checkOutput("pulse_width", low_cnt, PULSE_CYC);
                    in_low    = 0;
                    have_rise = 1;
                    high_cnt  = 0;
                end
                if (have_rise != 0 && bus_now != prev_bus) begin
                    checkOutput("hold_cycles", (high_cnt < HOLD_CYC + 1) ? high_cnt : HOLD_CYC + 1, HOLD_CYC + 1);
                end
                high_cnt++;
            end
        end
        prev_bus = bus_now;
    end

    // Reference model: host character rules applied to the text buffer and cursor.
    task automatic modelApply(input logic [7:0] c);
        logic [7:0] ch;
        if ((c >= 8'h20 && c <= 8'h5F) || (c >= 8'h61 && c <= 8'h7A)) begin
            ch = (c >= 8'h61) ? c - 8'h20 : c;
            mbuf[mcur] = ch[6:0];
            if (mcur < 15) mcur++;
        end else if (c == 8'h08) begin
            if (mcur > 0) begin
                mcur--;
                mbuf[mcur] = 7'h20;
            end
        end else if (c == 8'h0D) begin
            mcur = 0;
        end else if (c == 8'h0C) begin
            for (int i = 0; i < 16; i++) mbuf[i] = 7'h20;
            mcur = 0;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mbuf[i] = 7'h20;
        mcur = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge CLK);
        while (!bus_if.o_char_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("ready_wait", bus_if.o_char_ready, 1);
        checkOutput("cursor_before_send", bus_if.o_cursor, mcur);
        bus_if.i_char_valid = 1'b1;
        bus_if.i_char_data  = c;
        @(posedge CLK);
        modelApply(c);
        @(negedge CLK);
        acc_cyc = cyc;
        bus_if.i_char_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        @(negedge CLK);
        while ((bus_if.o_busy || !bus_if.o_char_ready) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("wait_idle_busy", bus_if.o_busy, 0);
    endtask

    task automatic checkDisplay();
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("display_p%0d", i), mdisp[i], mbuf[i]);
        end
    endtask

    task automatic checkBlankSequence();
        checkOutput("blank_count", wlog.size(), 16);
        for (int i = 0; i < 16 && i < wlog.size(); i++) begin
            checkOutput($sformatf("blank_pos%0d", i), wlog[i].pos, i);
            checkOutput($sformatf("blank_data%0d", i), wlog[i].data, 7'h20);
        end
        checkOutput("blank_gap_count", gaps.size(), 15);
        for (int i = 0; i < gaps.size(); i++) begin
            checkOutput($sformatf("blank_gap%0d", i), gaps[i], HOLD_CYC + 1 + SETUP_CYC);
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs [14];
        int          n0;
        int          n;
        int          r;
        logic [7:0]  c;

        vecs[0]  = '{8'h61, 1};
        vecs[1]  = '{8'h42, 2};
        vecs[2]  = '{8'h0D, 0};
        vecs[3]  = '{8'h08, 0};
        vecs[4]  = '{8'h7A, 1};
        vecs[5]  = '{8'h6D, 2};
        vecs[6]  = '{8'h08, 1};
        vecs[7]  = '{8'h07, 1};
        vecs[8]  = '{8'h7F, 1};
        vecs[9]  = '{8'h60, 1};
        vecs[10] = '{8'h7E, 1};
        vecs[11] = '{8'h5F, 2};
        vecs[12] = '{8'h20, 3};
        vecs[13] = '{8'h0D, 0};

        bus_if.i_char_valid = 1'b0;
        bus_if.i_char_data  = 8'h00;
        for (int i = 0; i < 16; i++) mdisp[i] = 7'h7F;
        modelReset();

        repeat (3) @(negedge CLK);
        checkOutput("reset_wr_n", bus_if.HPDL_WR_N, 4'hF);
        checkOutput("reset_d", bus_if.HPDL_D, 7'h20);
        checkOutput("reset_a", bus_if.HPDL_A, 2'b11);
        checkOutput("reset_cursor", bus_if.o_cursor, 0);
        checkOutput("reset_ready", bus_if.o_char_ready, 0);
        checkOutput("reset_busy", bus_if.o_busy, 1);

        RST_N = 1'b1;
        waitIdle(600);
        checkBlankSequence();
        checkOutput("ready_after_blank", bus_if.o_char_ready, 1);
        checkDisplay();

        for (int i = 0; i < 14; i++) begin
            n0 = wlog.size();
            applyStimulus(vecs[i].code);
            checkOutput($sformatf("vec%0d_cursor", i), bus_if.o_cursor, vecs[i].exp_cursor);
            if (i == 0) begin
                n = 0;
                while (wlog.size() == n0 && n < 50) begin
                    @(negedge CLK);
                    n++;
                end
                checkOutput("first_write_latency", int'(fall_cyc - acc_cyc), 1 + SETUP_CYC);
            end
            if (i == 1) begin
                waitIdle(200);
                checkOutput("p0_is_A", mdisp[0], 7'h41);
                checkOutput("p1_is_B", mdisp[1], 7'h42);
            end
        end
        waitIdle(600);
        checkDisplay();

        applyStimulus(8'h0D);
        for (int i = 0; i < 17; i++) applyStimulus(8'h41 + 8'(i));
        checkOutput("cursor_saturated", bus_if.o_cursor, 15);
        waitIdle(800);
        checkDisplay();
        checkOutput("p15_is_Q", mdisp[15], 7'h51);
        checkOutput("p14_is_O", mdisp[14], 7'h4F);

        applyStimulus(8'h0D);
        waitIdle(200);
        n0 = wlog.size();
        applyStimulus(8'h08);
        checkOutput("bksp0_cursor", bus_if.o_cursor, 0);
        repeat (30) @(negedge CLK);
        checkOutput("bksp0_writes", wlog.size() - n0, 0);

        applyStimulus(8'h48);
        applyStimulus(8'h49);
        @(negedge CLK);
        n = 0;
        while (!bus_if.o_char_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        bus_if.i_char_valid = 1'b1;
        bus_if.i_char_data  = 8'h0C;
        @(posedge CLK);
        modelApply(8'h0C);
        @(negedge CLK);
        bus_if.i_char_data = 8'h58;
        n = 0;
        while (!bus_if.o_char_ready && n < 40) begin
            n++;
            @(negedge CLK);
        end
        checkOutput("ff_ready_low_cycles", n, 16);
        checkOutput("ff_cursor_home", bus_if.o_cursor, 0);
        @(posedge CLK);
        modelApply(8'h58);
        @(negedge CLK);
        bus_if.i_char_valid = 1'b0;
        checkOutput("ff_then_x_cursor", bus_if.o_cursor, 1);
        waitIdle(800);
        checkDisplay();
        checkOutput("ff_p0_is_X", mdisp[0], 7'h58);
        checkOutput("ff_p1_blank", mdisp[1], 7'h20);

        n0 = wlog.size();
        repeat (100) @(negedge CLK);
        checkOutput("idle_no_writes", wlog.size() - n0, 0);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45) c = 8'($urandom_range(8'h20, 8'h5F));
            else if (r < 65) c = 8'($urandom_range(8'h61, 8'h7A));
            else if (r < 75) c = 8'h08;
            else if (r < 82) c = 8'h0D;
            else if (r < 85) c = 8'h0C;
            else c = 8'($urandom_range(0, 255));
            applyStimulus(c);
            repeat ($urandom_range(0, 20)) @(negedge CLK);
            if ((i % 20) == 19) begin
                waitIdle(800);
                checkDisplay();
            end
        end

        applyStimulus(8'h52);
        n = 0;
        while (bus_if.HPDL_WR_N == 4'hF && n < 60) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("strobe_reached", int'(bus_if.HPDL_WR_N != 4'hF), 1);
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("async_reset_wr_n", bus_if.HPDL_WR_N, 4'hF);
        checkOutput("async_reset_ready", bus_if.o_char_ready, 0);
        checkOutput("async_reset_cursor", bus_if.o_cursor, 0);
        modelReset();
        wlog.delete();
        gaps.delete();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        waitIdle(600);
        checkBlankSequence();
        checkDisplay();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
